// File: rtl/dmem_responder.sv
// Word-addressed SRAM responder with a valid/ready request channel and a
// valid/ready response channel returned after LATENCY wait states.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int unsigned Words    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  WaitInit = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [Words];

    logic                  accept;
    logic                  do_access;
    logic                  mem_we;
    logic                  acc_write;
    logic                  acc_err;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_be;
    logic [DEPTH_LOG2-1:0] acc_idx;

    // Gated by rst so the requester never sees ready while reset is held.
    assign req_ready  = (state_q == StIdle) && rst;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign busy       = (state_q != StIdle);

    // In IDLE the access (zero-latency only) uses the live request payload.
    always_comb begin
        if (state_q == StIdle) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_write = write_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
        acc_err   = (acc_addr[1:0] != 2'b00) || (|acc_addr[31:DEPTH_LOG2+2]);
        acc_idx   = acc_addr[DEPTH_LOG2+1:2];
        do_access = ((state_q == StIdle) && accept && (LATENCY == 0))
                 || ((state_q == StWait) && (cnt_q == 4'd0));
        mem_we    = do_access && acc_write && !acc_err && rst;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    if (LATENCY == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_access) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_write) ? 32'd0 : mem[acc_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance, directed steps
// followed by random traffic checked against a word-array reference model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be    = 4'd0;
    logic        resp_ready = 1'b1;
    int          sel = 0;

    logic        rr0, rv0, re0, bz0;
    logic        rr1, rv1, re1, bz1;
    logic [31:0] rd0, rd1;

    logic        o_req_ready, o_resp_valid, o_resp_err, o_busy;
    logic [31:0] o_resp_rdata;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model [2][1024];
    time         acc_time;
    time         t_prev;
    logic [31:0] inj_addr = 32'd0;

    always #5 clk = ~clk;

    assign o_req_ready  = (sel != 0) ? rr1 : rr0;
    assign o_resp_valid = (sel != 0) ? rv1 : rv0;
    assign o_resp_rdata = (sel != 0) ? rd1 : rd0;
    assign o_resp_err   = (sel != 0) ? re1 : re0;
    assign o_busy       = (sel != 0) ? bz1 : bz0;

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_dut_lat2 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid && (sel == 0)),
        .req_ready  (rr0),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (rv0),
        .resp_ready (resp_ready),
        .resp_rdata (rd0),
        .resp_err   (re0),
        .busy       (bz0)
    );

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) u_dut_lat0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid && (sel == 1)),
        .req_ready  (rr1),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (rv1),
        .resp_ready (resp_ready),
        .resp_rdata (rd1),
        .resp_err   (re1),
        .busy       (bz1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s mismatched", tag);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the handshake.
    task automatic transact(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input int bp, input bit inject);
        int          lat;
        int          n;
        logic        exp_err;
        logic [31:0] exp_rd;
        lat     = (sel != 0) ? 0 : 2;
        exp_err = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd1024);
        exp_rd  = (wr || exp_err) ? 32'd0 : model[sel][addr[11:2]];

        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_be     = be;
        resp_ready = (bp == 0);
        n = 0;
        while (((sel != 0) ? rr1 : rr0) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_idle", o_req_ready, 32'd1);
        acc_time = $time;

        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            chk("resp_valid_timing", o_resp_valid, (k == lat + 1) ? 32'd1 : 32'd0);
            chk("busy_inflight", o_busy, 32'd1);
        end
        chk("resp_rdata", o_resp_rdata, exp_rd);
        chk("resp_err", o_resp_err, exp_err);
        chk("req_ready_resp", o_req_ready, 32'd0);

        for (int b = 1; b <= bp; b++) begin
            if (b == 1 && inject) begin
                req_valid = 1'b1;
                req_write = 1'b0;
                req_addr  = inj_addr;
            end
            @(negedge clk);
            chk("bp_resp_valid", o_resp_valid, 32'd1);
            chk("bp_rdata_stable", o_resp_rdata, exp_rd);
            chk("bp_err_stable", o_resp_err, exp_err);
            chk("bp_req_ready", o_req_ready, 32'd0);
            if (b == bp) resp_ready = 1'b1;
        end

        @(negedge clk);
        chk("post_resp_valid", o_resp_valid, 32'd0);
        chk("post_busy", o_busy, 32'd0);
        chk("post_req_ready", o_req_ready, 32'd1);

        if (wr && !exp_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) model[sel][addr[11:2]][8*i +: 8] = wdata[8*i +: 8];
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic        wr;
        logic [31:0] addr;
        int          r;

        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 1024; w++) model[s][w] = 32'd0;
        end

        // Reset values while held.
        repeat (3) @(negedge clk);
        chk("rst_req_ready0", rr0, 32'd0);
        chk("rst_req_ready1", rr1, 32'd0);
        chk("rst_resp_valid0", rv0, 32'd0);
        chk("rst_resp_valid1", rv1, 32'd0);
        chk("rst_busy0", bz0, 32'd0);
        chk("rst_rdata0", rd0, 32'd0);
        chk("rst_err0", re0, 32'd0);
        chk("rst_busy1", bz1, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_exit_ready0", rr0, 32'd1);
        chk("rst_exit_ready1", rr1, 32'd1);

        // Give the working window a known value in both arrays.
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int w = 0; w < 64; w++) transact(1'b1, 32'(w) << 2, 32'd0, 4'hF, 0, 1'b0);
        end

        // Full write, read-after-write.
        sel = 0;
        transact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        transact(1'b0, 32'h10, 32'd0, 4'h0, 0, 1'b0);

        // Partial write lanes 0 and 2.
        transact(1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0);
        transact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 1'b0);
        transact(1'b0, 32'h20, 32'd0, 4'h0, 0, 1'b0);
        chk("partial_word", o_resp_rdata, 32'd0);
        transact(1'b1, 32'h24, 32'h55555555, 4'h0, 0, 1'b0);
        transact(1'b0, 32'h24, 32'd0, 4'h0, 0, 1'b0);

        // Misaligned read and out-of-range write; 0x1000 must not alias word 0.
        transact(1'b0, 32'h6, 32'd0, 4'h0, 0, 1'b0);
        transact(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, 1'b0);
        transact(1'b0, 32'h0, 32'd0, 4'h0, 0, 1'b0);
        transact(1'b0, 32'h4, 32'd0, 4'h0, 0, 1'b0);

        // Back-pressure with a competing request held during the window.
        inj_addr = 32'h20;
        transact(1'b0, 32'h10, 32'd0, 4'h0, 5, 1'b1);
        transact(1'b0, 32'h20, 32'd0, 4'h0, 0, 1'b0);

        // Zero-latency instance: one transaction every two cycles.
        sel = 1;
        transact(1'b1, 32'h10, 32'h12345678, 4'hF, 0, 1'b0);
        t_prev = acc_time;
        for (int i = 0; i < 4; i++) begin
            transact(1'b0, 32'h10, 32'd0, 4'h0, 0, 1'b0);
            chk("lat0_throughput", 32'(acc_time - t_prev), 32'd20);
            t_prev = acc_time;
        end
        transact(1'b1, 32'h8, 32'hA5A5A5A5, 4'b1001, 0, 1'b0);
        transact(1'b0, 32'h8, 32'd0, 4'h0, 2, 1'b0);

        // Reset in the last WAIT cycle of a write aborts the commit.
        sel = 0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'hCAFEF00D;
        req_be    = 4'hF;
        resp_ready = 1'b1;
        n = 0;
        while (rr0 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mrst_accept", rr0, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mrst_wait1_busy", bz0, 32'd1);
        @(negedge clk);
        chk("mrst_wait0_busy", bz0, 32'd1);
        chk("mrst_wait0_valid", rv0, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mrst_held_valid", rv0, 32'd0);
            chk("mrst_held_busy", bz0, 32'd0);
            chk("mrst_held_ready", rr0, 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_exit_ready", rr0, 32'd1);
        chk("mrst_exit_valid", rv0, 32'd0);
        transact(1'b0, 32'h40, 32'd0, 4'h0, 0, 1'b0);

        // Random traffic across both instances.
        for (int t = 0; t < 150; t++) begin
            sel = int'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 9));
            if (r < 7) addr = 32'($urandom_range(0, 63)) << 2;
            else if (r == 7) addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
            else addr = $urandom | 32'h0000_1000;
            transact(wr, addr, $urandom, 4'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
